// File: rtl/ras_ring_ckpt_pkg.sv
// ras_ring_ckpt_pkg
// Shared frontend configuration for the return-address stack.
// Contents:
//   ras_cfg_t        - frontend configuration record (RAS depth, VLEN)
//   RAS_CFG_DEFAULT  - default configuration used as parameter defaults
//   ras_ptr_w()      - top-pointer width for a given depth (at least 1 bit)
//   ras_cnt_w()      - occupancy-counter width able to hold 0..depth
// The entry type (ras_t) and checkpoint type (ras_ckpt_t) are declared in
// the stack itself, sized with these helpers, because their widths follow
// the per-instance DEPTH/ADDR_W parameters.
package ras_ring_ckpt_pkg;

   typedef struct packed {
      int ras_depth;   // number of return-address entries
      int vlen;        // virtual address width
   } ras_cfg_t;

   localparam ras_cfg_t RAS_CFG_DEFAULT = '{ras_depth: 2, vlen: 64};

   function automatic int ras_ptr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic int ras_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ras_ring_ckpt.sv
// ras_ring_ckpt
// Circular return-address stack with a single-slot checkpoint/restore.
// A push onto a full stack overwrites the oldest entry rather than being
// dropped. The checkpoint records {ptr, count, top value}; restoring it
// repairs only the top slot, so deeper speculative overwrites are lost.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           empty the stack (entries retained, count/ptr zeroed)
//   push_i, data_i    call: push return address
//   pop_i             return: pop top
//   ckpt_i            capture pre-update state into checkpoint slot
//   restore_i         reload state from checkpoint slot
//   data_o            top-of-stack address
//   valid_o           stack non-empty
//   count_o           occupancy
//   overflow_o        pulse: previous push overwrote the oldest entry
//   underflow_o       pulse: previous pop found the stack empty
module ras_ring_ckpt
   import ras_ring_ckpt_pkg::*;
#(
   parameter int DEPTH  = RAS_CFG_DEFAULT.ras_depth,
   parameter int ADDR_W = RAS_CFG_DEFAULT.vlen,
   localparam int PTR_W = ras_ptr_w(DEPTH),
   localparam int CNT_W = ras_cnt_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] data_i,
   input  logic              ckpt_i,
   input  logic              restore_i,
   output logic [ADDR_W-1:0] data_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] ra;
   } ras_t;

   typedef struct packed {
      logic [PTR_W-1:0]  ptr;
      logic [CNT_W-1:0]  cnt;
      logic [ADDR_W-1:0] top;
   } ras_ckpt_t;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Explicit compare so that non-power-of-two depths wrap correctly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_LAST : p - PTR_W'(1);
   endfunction

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_next;
   logic [CNT_W-1:0]  cnt_q, cnt_next;
   ras_ckpt_t         ckpt_q, ckpt_next;
   logic              ovf_q, ovf_next;
   logic              unf_q, unf_next;

   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] wr_data;
   logic [DEPTH-1:0]  wr_hit;
   ras_t              top;

   always_comb begin
      ptr_next  = ptr_q;
      cnt_next  = cnt_q;
      ckpt_next = ckpt_q;
      ovf_next  = 1'b0;
      unf_next  = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = ptr_q;
      wr_data   = data_i;

      if (flush_i) begin
         ptr_next = '0;
         cnt_next = '0;
      end else if (restore_i) begin
         // Rewrite the saved top: undoes a speculative overwrite of that slot.
         ptr_next = ckpt_q.ptr;
         cnt_next = ckpt_q.cnt;
         wr_en    = 1'b1;
         wr_idx   = ckpt_q.ptr;
         wr_data  = ckpt_q.top;
      end else begin
         if (ckpt_i) begin
            ckpt_next = '{ptr: ptr_q, cnt: cnt_q, top: mem_q[ptr_q]};
         end
         if (push_i && pop_i) begin
            // Call-and-return in one instruction: replace the top in place.
            wr_en = 1'b1;
            if (cnt_q == '0) begin
               cnt_next = CNT_W'(1);
            end
         end else if (push_i) begin
            ptr_next = ptr_inc(ptr_q);
            wr_en    = 1'b1;
            wr_idx   = ptr_inc(ptr_q);
            if (cnt_q == CNT_FULL) begin
               ovf_next = 1'b1;
            end else begin
               cnt_next = cnt_q + CNT_W'(1);
            end
         end else if (pop_i) begin
            if (cnt_q != '0) begin
               ptr_next = ptr_dec(ptr_q);
               cnt_next = cnt_q - CNT_W'(1);
            end else begin
               unf_next = 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
         assign wr_hit[gi] = wr_en && (wr_idx == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q  <= '0;
         cnt_q  <= '0;
         ckpt_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ptr_q  <= ptr_next;
         cnt_q  <= cnt_next;
         ckpt_q <= ckpt_next;
         ovf_q  <= ovf_next;
         unf_q  <= unf_next;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) begin
               mem_q[i] <= wr_data;
            end
         end
      end
   end

   assign top         = '{valid: (cnt_q != '0), ra: mem_q[ptr_q]};
   assign data_o      = top.ra;
   assign valid_o     = top.valid;
   assign count_o     = cnt_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_ras_ring_ckpt.sv
// tb_ras_ring_ckpt
// Directed scoreboard bench. Two stacks (DEPTH=2 and DEPTH=3) share the
// stimulus. Each driven cycle pushes the hand-computed post-edge outputs
// into a queue; a monitor on the falling edge pops and compares.
module tb_ras_ring_ckpt;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0, flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
   logic        ckpt_i = 1'b0, restore_i = 1'b0;
   logic [63:0] data_i = '0;

   logic [63:0] d2_data, d3_data;
   logic        d2_valid, d3_valid, d2_ovf, d3_ovf, d2_unf, d3_unf;
   logic [1:0]  d2_count, d3_count;

   always #5 clk = ~clk;

   ras_ring_ckpt #(.DEPTH(2), .ADDR_W(64)) u_d2 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i),
      .pop_i(pop_i), .data_i(data_i), .ckpt_i(ckpt_i), .restore_i(restore_i),
      .data_o(d2_data), .valid_o(d2_valid), .count_o(d2_count),
      .overflow_o(d2_ovf), .underflow_o(d2_unf)
   );

   ras_ring_ckpt #(.DEPTH(3), .ADDR_W(64)) u_d3 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i),
      .pop_i(pop_i), .data_i(data_i), .ckpt_i(ckpt_i), .restore_i(restore_i),
      .data_o(d3_data), .valid_o(d3_valid), .count_o(d3_count),
      .overflow_o(d3_ovf), .underflow_o(d3_unf)
   );

   // sel: 0 = check DEPTH=2 stack, 1 = DEPTH=3 stack, 2 = both
   typedef struct {
      int          sel;
      string       name;
      logic [63:0] data;
      logic        valid;
      int          count;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic [63:0] d,
                            input logic v, input int c, input logic o, input logic u);
      cmp({e.name, tag, ".data"},  d, e.data);
      cmp({e.name, tag, ".valid"}, 64'(v), 64'(e.valid));
      cmp({e.name, tag, ".count"}, 64'(c), 64'(e.count));
      cmp({e.name, tag, ".ovf"},   64'(o), 64'(e.ovf));
      cmp({e.name, tag, ".unf"},   64'(u), 64'(e.unf));
   endtask

   // Monitor: compares the outputs produced by the previous rising edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.sel != 1) check_dut("@d2", e, d2_data, d2_valid, int'(d2_count), d2_ovf, d2_unf);
         if (e.sel != 0) check_dut("@d3", e, d3_data, d3_valid, int'(d3_count), d3_ovf, d3_unf);
         $display("txn %-14s d2: data=%0h v=%0b c=%0d o=%0b u=%0b | d3: data=%0h v=%0b c=%0d o=%0b u=%0b",
                  e.name, d2_data, d2_valid, d2_count, d2_ovf, d2_unf,
                  d3_data, d3_valid, d3_count, d3_ovf, d3_unf);
      end
   end

   task automatic cyc(input string name, input logic r, input logic f, input logic ps,
                      input logic pp, input logic ck, input logic rs, input logic [63:0] d,
                      input int sel, input logic [63:0] ed, input logic ev, input int ec,
                      input logic eo, input logic eu);
      exp_t e;
      @(negedge clk);
      rst_i = r; flush_i = f; push_i = ps; pop_i = pp;
      ckpt_i = ck; restore_i = rs; data_i = d;
      @(posedge clk);
      e.sel = sel; e.name = name; e.data = ed; e.valid = ev;
      e.count = ec; e.ovf = eo; e.unf = eu;
      exp_q.push_back(e);
   endtask

   initial begin
      //   name            r f ps pp ck rs data     sel exp_data v  c  o  u
      // 1: basic push/pop
      cyc("reset",         1,0,0,0,0,0, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      cyc("t1_push1000",   0,0,1,0,0,0, 64'h1000, 0, 64'h1000, 1, 1, 0, 0);
      cyc("t1_push2000",   0,0,1,0,0,0, 64'h2000, 0, 64'h2000, 1, 2, 0, 0);
      cyc("t1_pop",        0,0,0,1,0,0, 64'h0,    0, 64'h1000, 1, 1, 0, 0);
      // 2: overflow wrap and underflow
      cyc("t2_reset",      1,0,0,0,0,0, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      cyc("t2_pushA",      0,0,1,0,0,0, 64'hA,    0, 64'hA,    1, 1, 0, 0);
      cyc("t2_pushB",      0,0,1,0,0,0, 64'hB,    0, 64'hB,    1, 2, 0, 0);
      cyc("t2_pushC",      0,0,1,0,0,0, 64'hC,    0, 64'hC,    1, 2, 1, 0);
      cyc("t2_pop1",       0,0,0,1,0,0, 64'h0,    0, 64'hB,    1, 1, 0, 0);
      cyc("t2_pop2",       0,0,0,1,0,0, 64'h0,    0, 64'hC,    0, 0, 0, 0);
      cyc("t2_pop_empty",  0,0,0,1,0,0, 64'h0,    0, 64'hC,    0, 0, 0, 1);
      cyc("t2_idle",       0,0,0,0,0,0, 64'h0,    0, 64'hC,    0, 0, 0, 0);
      // 3: simultaneous push+pop
      cyc("t3_reset",      1,0,0,0,0,0, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      cyc("t3_push40",     0,0,1,0,0,0, 64'h40,   0, 64'h40,   1, 1, 0, 0);
      cyc("t3_pushpop80",  0,0,1,1,0,0, 64'h80,   0, 64'h80,   1, 1, 0, 0);
      cyc("t3_pop",        0,0,0,1,0,0, 64'h0,    0, 64'h0,    0, 0, 0, 0);
      cyc("t3_pp_empty",   0,0,1,1,0,0, 64'h80,   0, 64'h80,   1, 1, 0, 0);
      // 4: checkpoint/restore on DEPTH=3; only the top slot is repaired
      cyc("t4_reset",      1,0,0,0,0,0, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      cyc("t4_push1",      0,0,1,0,0,0, 64'h1,    1, 64'h1,    1, 1, 0, 0);
      cyc("t4_push2",      0,0,1,0,0,0, 64'h2,    1, 64'h2,    1, 2, 0, 0);
      cyc("t4_ckpt",       0,0,0,0,1,0, 64'h0,    1, 64'h2,    1, 2, 0, 0);
      cyc("t4_push3",      0,0,1,0,0,0, 64'h3,    1, 64'h3,    1, 3, 0, 0);
      cyc("t4_push4",      0,0,1,0,0,0, 64'h4,    1, 64'h4,    1, 3, 1, 0);
      cyc("t4_restore",    0,0,0,0,0,1, 64'h0,    1, 64'h2,    1, 2, 0, 0);
      cyc("t4_pop",        0,0,0,1,0,0, 64'h0,    1, 64'h4,    1, 1, 0, 0);
      // 5: flush beats push; DEPTH=2 slot 0 holds the restored 0x2
      cyc("t5_flush_push", 0,1,1,0,0,0, 64'h5,    0, 64'h2,    0, 0, 0, 0);
      cyc("t5_push6",      0,0,1,0,0,0, 64'h6,    0, 64'h6,    1, 1, 0, 0);
      // 6: reset beats restore and pending overflow; checkpoint cleared
      cyc("t6_push7",      0,0,1,0,0,0, 64'h7,    0, 64'h7,    1, 2, 0, 0);
      cyc("t6_push8",      0,0,1,0,0,0, 64'h8,    0, 64'h8,    1, 2, 1, 0);
      cyc("t6_rst_rest",   1,0,0,0,0,1, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      cyc("t6_restore",    0,0,0,0,0,1, 64'h0,    2, 64'h0,    0, 0, 0, 0);
      // ckpt is ignored while flush is high
      cyc("t7_push9",      0,0,1,0,0,0, 64'h9,    0, 64'h9,    1, 1, 0, 0);
      cyc("t7_flush_ckpt", 0,1,0,0,1,0, 64'h0,    0, 64'h0,    0, 0, 0, 0);
      cyc("t7_restore",    0,0,0,0,0,1, 64'h0,    0, 64'h0,    0, 0, 0, 0);

      @(negedge clk);
      rst_i = 0; flush_i = 0; push_i = 0; pop_i = 0; ckpt_i = 0; restore_i = 0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ras_ring_ckpt.md
Name: ras_ring_ckpt

Overview:
Parametrised return-address stack for the frontend branch predictor, sized from the RAS depth configuration field. It is implemented as a circular buffer: on overflow it overwrites the oldest entry instead of dropping the push. It adds a single-slot checkpoint/restore so the frontend can repair the stack after a mispredicted call or return. Sits beside the BTB/BHT in the frontend; the frontend drives push/pop and the controller drives flush/restore.

Parameters:
DEPTH, 2, number of return-address entries; legal range 1..64; non-power-of-two values are legal.
ADDR_W, 64, return-address width in bits (VLEN).
PTR_W, max(1,$clog2(DEPTH)), derived pointer width; not overridable.
CNT_W, $clog2(DEPTH+1), derived occupancy-counter width; not overridable.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, synchronous, active-high
flush_i  in  1  empty the stack
push_i  in  1  call detected; push data_i
pop_i  in  1  return detected; pop top
data_i  in  ADDR_W  return address to push
ckpt_i  in  1  capture current stack state into the checkpoint slot
restore_i  in  1  restore stack state from the checkpoint slot
data_o  out  ADDR_W  top-of-stack address
valid_o  out  1  stack non-empty
count_o  out  CNT_W  current occupancy
overflow_o  out  1  one-cycle pulse: the previous push overwrote the oldest entry
underflow_o  out  1  one-cycle pulse: the previous pop found the stack empty

Behaviour:
- Reset (rst_i sampled high at a clock edge) clears ptr_q, count_q, all mem entries, the checkpoint slot, overflow_o and underflow_o; therefore data_o=0, valid_o=0, count_o=0. Reset mid-sequence discards all state, including the checkpoint.
- Read path is zero-latency: data_o=mem[ptr_q], valid_o=(count_q!=0), count_o=count_q, all driven from registers.
- ptr_q indexes the top entry. Increment wraps DEPTH-1 -> 0; decrement wraps 0 -> DEPTH-1. Wrap uses an explicit compare, not bit truncation, so non-power-of-two DEPTH works.
- Priority per cycle: rst_i > flush_i > restore_i > push/pop. ckpt_i is independent of push/pop but is ignored when flush_i or restore_i is high.
- Push only: ptr_q+1; mem[ptr+1]=data_i; count_q=min(count_q+1,DEPTH). If count_q==DEPTH, the oldest entry is overwritten and overflow_o=1 in the next cycle.
- Pop only, count_q>0: ptr_q-1; count_q-1; mem unchanged.
- Pop only, count_q==0: no state change; underflow_o=1 in the next cycle.
- Push and pop together (e.g. jalr ra,ra): mem[ptr_q]=data_i; ptr_q unchanged. count_q unchanged if >0; if count_q==0, count becomes 1 and no underflow pulse is raised.
- flush_i: count_q=0, ptr_q=0; mem contents retained; push/pop/ckpt in the same cycle are ignored.
- ckpt_i: captures the pre-update {ptr_q, count_q, mem[ptr_q]} into the checkpoint slot. A push/pop in the same cycle still executes.
- restore_i: ptr_q and count_q are loaded from the checkpoint slot, and mem[ckpt.ptr] is rewritten with the saved top value, repairing a speculative overwrite. push/pop/ckpt in the same cycle are ignored. Restore without a prior ckpt yields the reset state.
- overflow_o/underflow_o are registered and high for exactly one cycle per event; flush and restore clear them.
- DEPTH=1: ptr_q is held at 0; push always overwrites; count saturates at 1.

Decomposition:
- Shared frontend/config package: ras_t {valid, ra[ADDR_W]} and ras_ckpt_t {ptr, cnt, top}, both parametrised through the configuration struct; the depth comes from the existing RAS-depth config field.
- No sub-module required. Pointer inc/dec-with-wrap is a local function, not a separate module.

Test Plan:
1. Reset, then DEPTH=2, push 0x1000 then 0x2000 -> data_o=0x2000, count_o=2; pop -> data_o=0x1000, count_o=1.
2. DEPTH=2, push 0xA, 0xB, 0xC -> overflow_o pulses one cycle after the third push; data_o=0xC, count_o=2; pop, pop -> data_o=0xB then valid_o=0; a further pop -> underflow_o pulse, count_o stays 0.
3. count_o=1 top 0x40, push+pop with data_i=0x80 -> data_o=0x80, count_o=1, no pulses; repeat on empty stack -> count_o=1, data_o=0x80, no underflow.
4. DEPTH=3, push 0x1, 0x2; ckpt_i; push 0x3, 0x4 (overwrites 0x1); restore_i -> count_o=2, data_o=0x2; pop -> data_o=0x1 restored? No: 0x1 is not recovered; check data_o equals the overwritten slot's value, documenting the single-top-repair limit.
5. flush_i together with push_i=1, data_i=0x5 -> count_o=0, valid_o=0, ptr reset; then push 0x6 -> data_o=0x6, count_o=1.
6. rst_i asserted mid-sequence with restore_i=1 and a pending overflow pulse -> next cycle all outputs 0; a subsequent restore_i yields count_o=0.
